// File: rtl/mic_pkg.sv
// Shared definitions for the microphone sample FIFO: default widths, counter width
// and the sample record type.
package mic_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_TS_W   = 32;
  localparam int OVF_CNT_W  = 16;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_TS_W-1:0]   ts;
  } mic_sample_t;

endpackage

// File: rtl/mic_sample_fifo_if.sv
// Sample stream interface between the CIC producer, the FIFO and the processor reader.
interface mic_sample_fifo_if #(
  parameter int DATA_W = mic_pkg::DEF_DATA_W,
  parameter int TS_W   = mic_pkg::DEF_TS_W
);

  // in_valid is a one-cycle strobe with no backpressure.
  // A read transfer happens on every clock edge where rd_valid && rd_ready are both high;
  // rd_data/rd_ts hold steady while rd_valid is high and rd_ready is low.
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] rd_data;
  logic [TS_W-1:0]   rd_ts;
  logic              rd_valid;
  logic              rd_ready;

  modport master (
    output in_data, in_valid, rd_ready,
    input  rd_data, rd_ts, rd_valid
  );

  modport slave (
    input  in_data, in_valid, rd_ready,
    output rd_data, rd_ts, rd_valid
  );

endinterface

// File: rtl/mic_sample_fifo_ram.sv
// Simple dual-port sample RAM: one write port and one registered, enable-gated read port.
// The read register doubles as the FIFO head register, so it alone carries a reset.
module mic_fifo_ram #(
  parameter int WORD_W = 64,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_data_q;
  logic [WORD_W-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/mic_sample_fifo.sv
// First-word-fall-through microphone sample FIFO with overflow counting.
// Define MIC_FIFO_TIMESTAMP_EN to tag each sample with a free-running cycle timestamp.
module mic_sample_fifo
  import mic_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int TS_W      = DEF_TS_W,
  parameter int DEPTH     = 64,
  parameter int AFULL_LVL = 48
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mic_sample_fifo_if.slave       bus,
  input  logic                   flush,
  input  logic                   ovf_clr,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic [OVF_CNT_W-1:0]   ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef MIC_FIFO_TIMESTAMP_EN
  localparam int WORD_W = DATA_W + TS_W;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam logic [LW-1:0]        FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0]        AF_LVL   = LW'(AFULL_LVL);
  localparam logic [OVF_CNT_W-1:0] OVF_MAX  = '1;

  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic [LW-1:0]        ram_cnt;
  logic                 rd_valid_q, rd_valid_d;
  logic                 almost_full_q, almost_full_d;
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic                 wr_en, ovf_inc, pop, load;
  logic [WORD_W-1:0]    wr_word, rd_word;

  always_comb begin
    wr_en   = bus.in_valid && !flush && (level_q < FULL_LVL);
    ovf_inc = bus.in_valid && !flush && (level_q == FULL_LVL);
    pop     = rd_valid_q && bus.rd_ready;
    // Entries still in the RAM, i.e. not yet moved into the head register.
    ram_cnt = level_q - LW'(rd_valid_q);
    load    = !flush && (ram_cnt != '0) && (!rd_valid_q || pop);

    wr_ptr_d   = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = load ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(wr_en) - LW'(pop);
    rd_valid_d = load | (rd_valid_q & ~pop);
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      rd_valid_d = 1'b0;
    end

    almost_full_d = (level_q >= AF_LVL);

    if (ovf_clr) begin
      ovf_cnt_d = ovf_inc ? OVF_CNT_W'(1) : '0;
    end else if (ovf_inc && (ovf_cnt_q != OVF_MAX)) begin
      ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      rd_valid_q    <= 1'b0;
      almost_full_q <= 1'b0;
      ovf_cnt_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      rd_valid_q    <= rd_valid_d;
      almost_full_q <= almost_full_d;
      ovf_cnt_q     <= ovf_cnt_d;
    end
  end

`ifdef MIC_FIFO_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q + TS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign wr_word     = {bus.in_data, ts_q};
  assign bus.rd_data = rd_word[WORD_W-1 -: DATA_W];
  assign bus.rd_ts   = rd_word[TS_W-1:0];
`else
  assign wr_word     = bus.in_data;
  assign bus.rd_data = rd_word;
  assign bus.rd_ts   = {TS_W{1'b0}};
`endif

  mic_fifo_ram #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_word),
    .rd_en   (load),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_word)
  );

  assign bus.rd_valid = rd_valid_q;
  assign level        = level_q;
  assign almost_full  = almost_full_q;
  assign ovf_cnt      = ovf_cnt_q;

endmodule
